// File: rtl/four_bank_mem_resp.sv
// Four-bank interleaved 16-bit word memory responder: per-bank busy windows and a fixed-latency
// read pipeline. Define MEM_STALL_STATS_EN to add saturating stall/error event counters.
module four_bank_mem_resp #(
   parameter int unsigned BANK_WORDS = 8192,
   parameter int unsigned BUSY_CYC   = 4,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] DataOut,
   output logic        stall,
   output logic [3:0]  busy,
   output logic        err
`ifdef MEM_STALL_STATS_EN
   ,
   output logic [15:0] stall_count,
   output logic [15:0] err_count
`endif
);

   localparam int unsigned RowW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
   localparam int unsigned CntW = (BUSY_CYC > 2) ? $clog2(BUSY_CYC) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(BUSY_CYC - 1);

   logic [1:0]      bank;
   logic [RowW-1:0] row;
   logic            req_valid;
   logic            illegal;
   logic            accept;

   assign bank = Addr[2:1];
   // Upper row bits alias when the bank is smaller than the address space.
   assign row  = RowW'(32'(Addr[15:3]) % BANK_WORDS);

   assign req_valid = rd ^ wr;
   assign illegal   = (rd & wr) | ((rd | wr) & Addr[0]);
   assign accept    = !rst && req_valid && !Addr[0] && !busy[bank];
   assign stall     = !rst && req_valid && !Addr[0] && busy[bank];

   // ---------------------------------------------------------------------------------------
   // Per-bank busy counters
   // ---------------------------------------------------------------------------------------
   logic [CntW-1:0] cnt_q [4];
   logic [CntW-1:0] cnt_d [4];

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         cnt_d[b] = cnt_q[b];
         if (accept && (bank == 2'(b))) begin
            cnt_d[b] = CntLoad;
         end else if (cnt_q[b] != '0) begin
            cnt_d[b] = cnt_q[b] - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int b = 0; b < 4; b++) begin
         busy[b] = (cnt_q[b] != '0);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Storage: contents survive reset
   // ---------------------------------------------------------------------------------------
   logic [15:0] mem_q [4][BANK_WORDS];

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         mem_q[bank][row] <= DataIn;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Read return pipeline
   // ---------------------------------------------------------------------------------------
   logic [RD_LAT-1:0] vld_q;
   logic [15:0]       dat_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= accept && rd;
         if (accept && rd) begin
            dat_q[0] <= mem_q[bank][row];
         end
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign DataOut = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : 16'h0000;

   // ---------------------------------------------------------------------------------------
   // Error flag
   // ---------------------------------------------------------------------------------------
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= illegal;
      end
   end

   assign err = err_q;

`ifdef MEM_STALL_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (illegal && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign stall_count = stall_cnt_q;
   assign err_count   = err_cnt_q;
`else
   // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed self-checking bench for four_bank_mem_resp (default parameters).
// Define MEM_STALL_STATS_EN to also check the stall/error counters.
module tb_four_bank_mem_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        rd;
   logic        wr;
   logic [15:0] DataOut;
   logic        stall;
   logic [3:0]  busy;
   logic        err;
`ifdef MEM_STALL_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] err_count;
`endif

   int checks   = 0;
   int failures = 0;

   four_bank_mem_resp dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (Addr),
      .DataIn     (DataIn),
      .rd         (rd),
      .wr         (wr),
      .DataOut    (DataOut),
      .stall      (stall),
      .busy       (busy),
`ifdef MEM_STALL_STATS_EN
      .stall_count(stall_count),
      .err_count  (err_count),
`endif
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      rd     = r;
      wr     = w;
      Addr   = a;
      DataIn = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Write one word, then idle until every bank is free again.
   task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
      logic [3:0] exp_busy;
      exp_busy = 4'b0001 << a[2:1];
      drive(1'b0, 1'b1, a, d);
      sample();
      check("wr_stall", 32'(stall), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("wr_busy", 32'(busy), 32'(exp_busy));
      repeat (3) step();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) step();
      rst = 1'b0;
      sample();
      check("rst_dout", 32'(DataOut), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
`ifdef MEM_STALL_STATS_EN
      check("rst_stall_count", 32'(stall_count), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
`endif
      step();

      wr_word(16'h0000, 16'h5A5A);
      wr_word(16'h0002, 16'h0202);
      wr_word(16'h0010, 16'hBEEF);

      // Single read: data only in N+2
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
         else        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         sample();
         if (i == 0) check("rd_stall", 32'(stall), 32'd0);
         check("rd_dout", 32'(DataOut), (i == 2) ? 32'hBEEF : 32'd0);
         step();
      end

      // Preload line words on consecutive cycles across all banks
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'h0040 + 16'(2 * i), 16'(i + 1));
         sample();
         check("pre_stall", 32'(stall), 32'd0);
         step();
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("pre_busy", 32'(busy), 32'b1110);
      repeat (3) step();

      // Line fill
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000);
         else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         sample();
         if (i < 4) check("fill_stall", 32'(stall), 32'd0);
         check("fill_dout", 32'(DataOut), (i >= 2) ? 32'(i - 1) : 32'd0);
         step();
      end

      // Bank conflict
      drive(1'b0, 1'b1, 16'h0008, 16'h1234);
      sample();
      check("cf_wr_stall", 32'(stall), 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 16'h0000, 16'h0000);
         sample();
         check("cf_stall", 32'(stall), 32'd1);
         check("cf_busy0", 32'(busy[0]), 32'd1);
         step();
      end
      drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("cf_accept", 32'(stall), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("cf_dout1", 32'(DataOut), 32'd0);
      step();
      sample();
      check("cf_dout2", 32'(DataOut), 32'h5A5A);
`ifdef MEM_STALL_STATS_EN
      check("cf_stall_count", 32'(stall_count), 32'd3);
`endif
      repeat (3) step();

      // Illegal: rd and wr together
      drive(1'b1, 1'b1, 16'h0002, 16'hFFFF);
      sample();
      check("ill_both_stall", 32'(stall), 32'd0);
      check("ill_both_err0", 32'(err), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("ill_both_err", 32'(err), 32'd1);
      check("ill_both_busy", 32'(busy), 32'd0);
      step();
      sample();
      check("ill_err_clear", 32'(err), 32'd0);
      step();

      // Illegal: odd address read
      drive(1'b1, 1'b0, 16'h0003, 16'h0000);
      sample();
      check("ill_odd_stall", 32'(stall), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("ill_odd_err", 32'(err), 32'd1);
      check("ill_odd_dout1", 32'(DataOut), 32'd0);
      step();
      sample();
      check("ill_odd_dout2", 32'(DataOut), 32'd0);
`ifdef MEM_STALL_STATS_EN
      check("ill_err_count", 32'(err_count), 32'd2);
`endif
      step();

      // Memory untouched by the illegal write
      drive(1'b1, 1'b0, 16'h0002, 16'h0000);
      sample();
      check("ill_rb_stall", 32'(stall), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      sample();
      check("ill_rb_dout", 32'(DataOut), 32'h0202);
      step();

      // Reset mid-read
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      sample();
      check("mr_stall", 32'(stall), 32'd0);
      step();
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      rst = 1'b0;
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      sample();
      check("mr_dout", 32'(DataOut), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_stall2", 32'(stall), 32'd0);
`ifdef MEM_STALL_STATS_EN
      check("mr_stall_count", 32'(stall_count), 32'd0);
      check("mr_err_count", 32'(err_count), 32'd0);
`endif
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sample();
      check("mr_dout_n1", 32'(DataOut), 32'd0);
      step();
      sample();
      check("mr_retained", 32'(DataOut), 32'hBEEF);
      step();
      sample();
      check("mr_dout_n3", 32'(DataOut), 32'd0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
